// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core's fetch port, filled over a big-endian byte stream.
// The core is held in reset until a complete image has been written.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       addr,
  output logic [31:0]       inst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              core_hold_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [23:0]       word;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   len_clamp;
  logic              last_word;
  logic              start_acc;
  logic              byte_acc;
  logic              word_wr;
  logic              in_range;
  logic              unused_addr_bits;

  logic [31:0] mem [DEPTH];

  assign len_clamp = (load_len > DEPTH_L) ? DEPTH_L : load_len;
  assign last_word = (({1'b0, wr_ptr} + (ADDR_W + 1)'(1)) == len);

  // Fetch path: only a fully loaded image is visible to the core.
  assign in_range         = (addr[31:ADDR_W+2] == '0);
  assign unused_addr_bits = ^addr[1:0];
  assign inst = (ce && (state == DONE) && in_range) ? mem[addr[ADDR_W+1:2]] : 32'h0;

  always_comb begin
    state_nxt   = state;
    load_ready  = 1'b0;
    load_busy   = 1'b0;
    load_done   = 1'b0;
    core_hold_o = 1'b1;
    start_acc   = 1'b0;
    byte_acc    = 1'b0;
    word_wr     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          load_done   = 1'b1;
          core_hold_o = 1'b0;
        end
        if (load_start) begin
          start_acc = 1'b1;
          state_nxt = (len_clamp == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        load_busy  = 1'b1;
        byte_acc   = load_valid;
        if (load_valid && (byte_cnt == 2'd3)) begin
          word_wr = 1'b1;
          if (last_word) state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= 2'd0;
      wr_ptr   <= '0;
      word     <= 24'h0;
      len      <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        len      <= len_clamp;
        wr_ptr   <= '0;
        byte_cnt <= 2'd0;
        word     <= 24'h0;
      end
      if (byte_acc) begin
        word     <= {word[15:0], load_byte};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (word_wr) wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Array is deliberately left out of reset so an image survives a core restart.
  always_ff @(posedge clk) begin
    if (word_wr) mem[wr_ptr] <= {word, load_byte};
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: image loads, fetch window, clamping and reset mid-load.
module tb_inst_rom_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ce = 1'b0;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       inst;
  logic              load_start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              load_valid = 1'b0;
  logic [7:0]        load_byte = 8'h0;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic              core_hold_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];

  inst_rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .addr       (addr),
    .inst       (inst),
    .load_start (load_start),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .core_hold_o(core_hold_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pat(input int i);
    logic [7:0] a;
    logic [7:0] b;
    a = i[7:0];
    b = i[15:8];
    return {a, b ^ 8'h5A, ~a, a ^ 8'h3C};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    load_valid = 1'b1;
    load_byte  = b;
    while (load_ready !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    if (n == 16) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: load_ready=%b after %0d cycles, required 1", load_ready, n);
    end
    tick();
    load_valid = 1'b0;
  endtask

  task automatic start_load(input int len, input logic with_byte);
    load_start = 1'b1;
    load_len   = (ADDR_W + 1)'(len);
    if (with_byte) begin
      load_valid = 1'b1;
      load_byte  = 8'h11;
    end
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    ce = 1'b1;
    addr = 32'h0;
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front();
    vectors++;
    if (inst !== e) begin
      miscompares++;
      $display("FAIL reset_inst: got %h, required %h", inst, e);
    end
    vectors++;
    if ({load_done, core_hold_o, load_busy, load_ready} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_ctrl: done/hold/busy/ready got %b, required 0100",
               {load_done, core_hold_o, load_busy, load_ready});
    end
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({load_done, core_hold_o, load_busy, load_ready} !== 4'b0100) begin
      miscompares++;
      $display("FAIL idle_ctrl: done/hold/busy/ready got %b, required 0100",
               {load_done, core_hold_o, load_busy, load_ready});
    end
  endtask

  task automatic test_load2(input logic gap);
    logic [31:0] w [2];
    logic [31:0] e;
    w[0] = 32'h3402000F;
    w[1] = 32'h34030010;
    start_load(2, 1'b0);
    vectors++;
    if ({load_busy, load_ready, core_hold_o, load_done} !== 4'b1110) begin
      miscompares++;
      $display("FAIL load2_enter gap=%0b: busy/ready/hold/done got %b, required 1110",
               gap, {load_busy, load_ready, core_hold_o, load_done});
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(w[k]);
      for (int j = 0; j < 4; j++) begin
        send_byte(w[k][31-8*j -: 8]);
        if (gap && !(k == 1 && j == 3)) begin
          tick();
          vectors++;
          if (load_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL load2_gap_ready: byte %0d got %b, required 1", 4*k+j, load_ready);
          end
        end
      end
    end
    vectors++;
    if ({load_done, core_hold_o, load_busy, load_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL load2_done gap=%0b: done/hold/busy/ready got %b, required 1000",
               gap, {load_done, core_hold_o, load_busy, load_ready});
    end
    for (int k = 0; k < 2; k++) begin
      ce = 1'b1;
      addr = 32'(k * 4);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (inst !== e) begin
        miscompares++;
        $display("FAIL load2_word%0d gap=%0b: got %h, required %h", k, gap, inst, e);
      end
    end
  endtask

  task automatic test_overlen();
    logic [31:0] w;
    logic [31:0] e;
    start_load(DEPTH + 5, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      w = pat(i);
      exp_q.push_back(w);
      if (i == DEPTH - 1) begin
        vectors++;
        if (load_busy !== 1'b1) begin
          miscompares++;
          $display("FAIL overlen_busy: before last word got %b, required 1", load_busy);
        end
      end
      for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8]);
    end
    vectors++;
    if ({load_done, core_hold_o, load_busy, load_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL overlen_done: done/hold/busy/ready got %b, required 1000",
               {load_done, core_hold_o, load_busy, load_ready});
    end
    // Bytes offered while DONE must be ignored.
    load_valid = 1'b1;
    load_byte  = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    load_valid = 1'b0;
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL done_ready: got %b, required 0", load_ready);
    end
    ce = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      addr = 32'(i * 4);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (inst !== e) begin
        miscompares++;
        $display("FAIL overlen_word%0d: got %h, required %h", i, inst, e);
      end
    end
  endtask

  task automatic test_fetch_bounds();
    logic [31:0] addrs [5];
    logic        ces   [5];
    logic [31:0] e;
    addrs[0] = 32'h0000_0000; ces[0] = 1'b0; exp_q.push_back(32'h0);
    addrs[1] = 32'h0001_0000; ces[1] = 1'b1; exp_q.push_back(32'h0);
    addrs[2] = 32'h0000_1000; ces[2] = 1'b1; exp_q.push_back(32'h0);
    addrs[3] = 32'h0000_0006; ces[3] = 1'b1; exp_q.push_back(pat(1));
    addrs[4] = 32'h0000_0FFF; ces[4] = 1'b1; exp_q.push_back(pat(DEPTH - 1));
    for (int i = 0; i < 5; i++) begin
      ce = ces[i];
      addr = addrs[i];
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (inst !== e) begin
        miscompares++;
        $display("FAIL fetch_bound ce=%b addr=%h: got %h, required %h", ce, addr, inst, e);
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    logic [7:0]  bytes [5];
    logic [31:0] e;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    start_load(2, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(bytes[i]);
    rst = 1'b1;
    #1;
    vectors++;
    if ({load_done, core_hold_o, load_busy, load_ready} !== 4'b0100) begin
      miscompares++;
      $display("FAIL midload_rst: done/hold/busy/ready got %b, required 0100",
               {load_done, core_hold_o, load_busy, load_ready});
    end
    tick();
    rst = 1'b0;
    tick();
    // Zero-length load exposes the surviving contents without writing anything.
    start_load(0, 1'b0);
    vectors++;
    if ({load_done, core_hold_o, load_busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL zero_len: done/hold/busy got %b, required 100",
               {load_done, core_hold_o, load_busy});
    end
    exp_q.push_back(32'h11223344);
    exp_q.push_back(pat(1));
    for (int k = 0; k < 2; k++) begin
      addr = 32'(k * 4);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (inst !== e) begin
        miscompares++;
        $display("FAIL midload_keep%0d: got %h, required %h", k, inst, e);
      end
    end
    // Reload with a byte offered alongside load_start; that byte must not be taken.
    start_load(1, 1'b1);
    vectors++;
    if ({load_busy, core_hold_o} !== 2'b11) begin
      miscompares++;
      $display("FAIL reload_enter: busy/hold got %b, required 11", {load_busy, core_hold_o});
    end
    exp_q.push_back(32'hAABBCCDD);
    exp_q.push_back(pat(1));
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    vectors++;
    if ({load_done, core_hold_o} !== 2'b10) begin
      miscompares++;
      $display("FAIL reload_done: done/hold got %b, required 10", {load_done, core_hold_o});
    end
    for (int k = 0; k < 2; k++) begin
      addr = 32'(k * 4);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (inst !== e) begin
        miscompares++;
        $display("FAIL reload_word%0d: got %h, required %h", k, inst, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load2(1'b0);
    test_load2(1'b1);
    test_overlen();
    test_fetch_bounds();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
